pedal_pulse_gen: RTL and testbench
==================================

Name: pedal_pulse_gen

Overview:
- Front end that creates the accel_pulse / decel_pulse stimuli consumed by the speed-level controller.
- Takes raw, asynchronous accelerator and brake push-buttons and synchronizes and debounces each one.
- Converts a press into one single-cycle step pulse, then auto-repeats at a fixed rate while the button is held.
- Arbitrates the two buttons so that brake always wins and the two pulses are never high in the same cycle.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed before a debounced level changes (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles from the first pulse to the second pulse while held.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses.
- COAST_PERIOD, 50000000: coast decel interval; used only with the optional feature.
- CNT_W, 26: width of all timers; every cycle parameter must be below 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- accel_btn  in  1  raw accelerator button, asynchronous
- brake_btn  in  1  raw brake button, asynchronous
- enable  in  1  pulse generation enable
- accel_pulse  out  1  one-cycle step-up request
- decel_pulse  out  1  one-cycle step-down request
- accel_held  out  1  debounced accelerator level
- brake_held  out  1  debounced brake level

Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: while rst_n=0, all outputs are 0, every timer is 0, synchronizers and debounced levels are 0, and the FSM is IDLE. This holds even if reset is asserted mid-hold.
- Synchronizer: each raw button passes through 2 flops.
- Debounce:
  - A counter counts consecutive cycles where the synchronized level differs from the debounced level. It clears on any match.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive mismatches.
  - accel_held and brake_held are the registered debounced levels.
- Latency: with a clean input, accel_pulse rises exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples accel_btn=1.
- FSM states: IDLE, ACC_WAIT, ACC_RPT, BRK_WAIT, BRK_RPT, LOCKOUT. Pulses are registered outputs.
  - IDLE: if brake_held=1, emit decel_pulse and go to BRK_WAIT. Otherwise, if accel_held=1, emit accel_pulse and go to ACC_WAIT. The timer clears.
  - ACC_WAIT: the timer counts. When REPEAT_DELAY cycles have elapsed since the previous pulse, emit accel_pulse, clear the timer and go to ACC_RPT.
  - ACC_RPT: emit accel_pulse every REPEAT_PERIOD cycles.
  - BRK_WAIT and BRK_RPT: identical to the accel states, using decel_pulse.
  - Accel release in ACC_* goes to IDLE with no pulse. Brake release in BRK_* goes to IDLE if accel_held=0, otherwise to LOCKOUT.
  - Brake pressed in any ACC_* state: next cycle emits decel_pulse and moves to BRK_WAIT. The accel timer is discarded.
  - Accel pressed during BRK_*: ignored.
  - LOCKOUT: no pulses. Goes to IDLE once accel_held=0, so accel requires release and re-press after a brake (brake itself is still honoured from LOCKOUT).
  - Both buttons rising in the same cycle from IDLE: brake wins.
- enable=0:
  - Pulses are forced to 0 that cycle.
  - The FSM goes to LOCKOUT if either held level is 1, otherwise to IDLE.
  - Debounce keeps running.
- Invariant: accel_pulse & decel_pulse is never 1. Each pulse is exactly 1 cycle wide.
- Timers saturate and never wrap.

Optional Feature:
- Macro: PEDAL_COAST_DECEL_EN.
- Defined: in IDLE with enable=1, a coast timer counts, and every COAST_PERIOD cycles emits a decel_pulse. The timer clears whenever the FSM leaves IDLE or any held level is 1.
- Undefined: no coast logic. IDLE is silent and COAST_PERIOD is unused.

Decomposition:
- Package pedal_pkg: FSM state enum (3-bit encoding) and the default cycle constants.
- Sub-module btn_debounce: 2-flop synchronizer plus debounce counter with parameter DEBOUNCE_CYCLES; instantiated once per button.
- The top level holds the FSM, the repeat timer and the optional coast timer.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, COAST_PERIOD=20):
1. rst_n=0 for 5 cycles, then release with buttons low for 50 cycles -> all outputs 0 and no pulses. Reassert rst_n mid-hold -> outputs drop to 0 immediately (asynchronously).
2. accel_btn high for 3 cycles, then low -> accel_held stays 0 and no pulse.
3. accel_btn held for 8 cycles -> exactly one accel_pulse, 7 edges after press. accel_held falls 6 edges after release.
4. accel_btn held 30 cycles past the first pulse (t0) -> accel_pulse at t0, t0+10, 13, 16, 19, 22, 25, 28. That is 8 pulses, with no decel_pulse.
5. Accel held, then brake pressed -> decel_pulse and no further accel_pulse. Release brake with accel still held -> LOCKOUT with no pulses. Release and re-press accel -> accel_pulse resumes.
6. enable dropped mid accel repeat -> pulses stop the same cycle. enable raised with accel still held -> no pulse until re-press. With PEDAL_COAST_DECEL_EN and idle -> decel_pulse every 20 cycles.

Source files
------------

// File: rtl/pedal_pkg.sv
// Shared state encoding and default timing constants for the pedal pulse front end.
package pedal_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACC_WAIT = 3'd1,
        ACC_RPT  = 3'd2,
        BRK_WAIT = 3'd3,
        BRK_RPT  = 3'd4,
        LOCKOUT  = 3'd5
    } pedal_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
    localparam int unsigned DEF_COAST_PERIOD    = 50000000;
    localparam int unsigned DEF_CNT_W           = 26;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-mismatch debounce counter.
module btn_debounce
    import pedal_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic held
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            held  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            // The counter never passes DB_LAST, so it cannot wrap.
            if (sync2 == held) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                held <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pedal_pulse_gen.sv
// Debounced accel/brake buttons to single-cycle step pulses with auto-repeat; brake wins.
// Optional coast decel in IDLE: define PEDAL_COAST_DECEL_EN.
module pedal_pulse_gen
    import pedal_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned COAST_PERIOD    = DEF_COAST_PERIOD,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accel_btn,
    input  logic brake_btn,
    input  logic enable,
    output logic accel_pulse,
    output logic decel_pulse,
    output logic accel_held,
    output logic brake_held
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam longint unsigned  CNT_LIMIT   = 64'd1 << CNT_W;

    if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0 || COAST_PERIOD == 0 ||
        DEBOUNCE_CYCLES >= CNT_LIMIT || REPEAT_DELAY >= CNT_LIMIT ||
        REPEAT_PERIOD >= CNT_LIMIT || COAST_PERIOD >= CNT_LIMIT) begin : g_param_check
        $error("pedal_pulse_gen: cycle parameters must be in 1 .. 2**CNT_W-1");
    end

    pedal_state_e     state;
    pedal_state_e     state_nx;
    logic             acc_d;
    logic             dec_d;
    logic             rpt_clr;
    logic             rpt_hit;
    logic             coast_fire;
    logic [CNT_W-1:0] rpt_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_accel_db (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (accel_btn),
        .held (accel_held)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_brake_db (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (brake_btn),
        .held (brake_held)
    );

    assign rpt_hit = (rpt_cnt == (((state == ACC_WAIT) || (state == BRK_WAIT)) ? DELAY_LAST : PERIOD_LAST));

`ifdef PEDAL_COAST_DECEL_EN
    localparam logic [CNT_W-1:0] COAST_LAST = CNT_W'(COAST_PERIOD - 1);

    logic             coast_run;
    logic [CNT_W-1:0] coast_cnt;

    assign coast_run  = (state == IDLE) && enable && !accel_held && !brake_held;
    assign coast_fire = coast_run && (coast_cnt == COAST_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coast_cnt <= '0;
        end else if (!coast_run || coast_fire) begin
            coast_cnt <= '0;
        end else if (!(&coast_cnt)) begin
            coast_cnt <= coast_cnt + CNT_W'(1);
        end
    end
`else
    assign coast_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            accel_pulse <= 1'b0;
            decel_pulse <= 1'b0;
            rpt_cnt     <= '0;
        end else begin
            state       <= state_nx;
            accel_pulse <= acc_d;
            decel_pulse <= dec_d;
            if (rpt_clr) begin
                rpt_cnt <= '0;
            end else if (!(&rpt_cnt)) begin
                rpt_cnt <= rpt_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = (accel_held || brake_held) ? LOCKOUT : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (brake_held)      state_nx = BRK_WAIT;
                    else if (accel_held) state_nx = ACC_WAIT;
                end
                ACC_WAIT, ACC_RPT: begin
                    if (brake_held)       state_nx = BRK_WAIT;
                    else if (!accel_held) state_nx = IDLE;
                    else if (rpt_hit)     state_nx = ACC_RPT;
                end
                BRK_WAIT, BRK_RPT: begin
                    if (!brake_held)  state_nx = accel_held ? LOCKOUT : IDLE;
                    else if (rpt_hit) state_nx = BRK_RPT;
                end
                LOCKOUT: begin
                    if (brake_held)       state_nx = BRK_WAIT;
                    else if (!accel_held) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Repeat timer only runs while a button stays held in a repeat state; everything else clears it.
    always_comb begin
        acc_d   = 1'b0;
        dec_d   = 1'b0;
        rpt_clr = 1'b1;
        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (brake_held)      dec_d = 1'b1;
                    else if (accel_held) acc_d = 1'b1;
                    else if (coast_fire) dec_d = 1'b1;
                end
                ACC_WAIT, ACC_RPT: begin
                    if (brake_held)      dec_d = 1'b1;
                    else if (accel_held) begin
                        if (rpt_hit) acc_d   = 1'b1;
                        else         rpt_clr = 1'b0;
                    end
                end
                BRK_WAIT, BRK_RPT: begin
                    if (brake_held) begin
                        if (rpt_hit) dec_d   = 1'b1;
                        else         rpt_clr = 1'b0;
                    end
                end
                LOCKOUT: begin
                    if (brake_held) dec_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pedal_pulse_gen.sv
// Directed bench for pedal_pulse_gen with DEBOUNCE=4, DELAY=10, PERIOD=3, COAST=20.
module tb_pedal_pulse_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic accel_btn;
    logic brake_btn;
    logic enable;
    logic accel_pulse;
    logic decel_pulse;
    logic accel_held;
    logic brake_held;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;
    int t0      = 0;
    int acc_q[$];
    int dec_q[$];
    int snap[$];
    int exp4[8] = '{0, 10, 13, 16, 19, 22, 25, 28};
    int rise;
    int fall;
    bit acc_held_seen = 1'b0;
    bit both_seen     = 1'b0;
    bit wide_seen     = 1'b0;
    bit prev_a        = 1'b0;
    bit prev_d        = 1'b0;

`ifdef PEDAL_COAST_DECEL_EN
    localparam int EXP_T1_DEC = 2;
`else
    localparam int EXP_T1_DEC = 0;
`endif

    pedal_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .COAST_PERIOD   (20),
        .CNT_W          (26)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .accel_btn  (accel_btn),
        .brake_btn  (brake_btn),
        .enable     (enable),
        .accel_pulse(accel_pulse),
        .decel_pulse(decel_pulse),
        .accel_held (accel_held),
        .brake_held (brake_held)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (accel_pulse && decel_pulse) both_seen = 1'b1;
        if ((accel_pulse && prev_a) || (decel_pulse && prev_d)) wide_seen = 1'b1;
        prev_a = accel_pulse;
        prev_d = decel_pulse;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
        if (accel_pulse) acc_q.push_back(t);
        if (decel_pulse) dec_q.push_back(t);
        if (accel_held)  acc_held_seen = 1'b1;
    endtask

    task automatic clear_log();
        acc_q.delete();
        dec_q.delete();
        t = 0;
    endtask

    task automatic wait_acc(input string tag);
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) tick();
        check(tag, (acc_q.size() > 0) ? acc_q[0] : -1, 7);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        accel_btn = 1'b0;
        brake_btn = 1'b0;
        enable    = 1'b1;

        // T1: reset state, quiet idle, asynchronous reset during a hold
        repeat (5) tick();
        check("t1_reset_outs", int'({accel_pulse, decel_pulse, accel_held, brake_held}), 0);
        rst_n = 1'b1;
        clear_log();
        repeat (50) tick();
        check("t1_idle_acc", acc_q.size(), 0);
        check("t1_idle_dec", dec_q.size(), EXP_T1_DEC);
        accel_btn = 1'b1;
        repeat (10) tick();
        check("t1_held_pre", int'(accel_held), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t1_async_rst", int'({accel_pulse, decel_pulse, accel_held, brake_held}), 0);
        accel_btn = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();

        // T2: short glitch rejected
        clear_log();
        acc_held_seen = 1'b0;
        accel_btn = 1'b1;
        repeat (3) tick();
        accel_btn = 1'b0;
        repeat (15) tick();
        check("t2_glitch_held", int'(acc_held_seen), 0);
        check("t2_glitch_pulse", acc_q.size(), 0);

        // T3: single press latency and release latency
        clear_log();
        rise = 0;
        accel_btn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (accel_held && rise == 0) rise = t;
        end
        accel_btn = 1'b0;
        fall = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!accel_held && fall == 0) fall = t - 8;
        end
        check("t3_held_rise", rise, 6);
        check("t3_held_fall", fall, 6);
        check("t3_pulse_cnt", acc_q.size(), 1);
        check("t3_pulse_time", (acc_q.size() > 0) ? acc_q[0] : -1, 7);
        check("t3_no_decel", dec_q.size(), 0);

        // T4: auto-repeat schedule
        clear_log();
        accel_btn = 1'b1;
        wait_acc("t4_first_lat");
        t0 = (acc_q.size() > 0) ? acc_q[0] : 0;
        repeat (30) tick();
        snap = acc_q;
        check("t4_rpt_count", snap.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t4_rpt_%0d", i), (i < snap.size()) ? snap[i] - t0 : -1, exp4[i]);
        check("t4_no_decel", dec_q.size(), 0);
        accel_btn = 1'b0;
        repeat (12) tick();

        // T5: brake pre-empts accel, lockout, re-press
        clear_log();
        accel_btn = 1'b1;
        wait_acc("t5_acc_lat");
        clear_log();
        brake_btn = 1'b1;
        for (int i = 0; i < 20 && dec_q.size() == 0; i++) tick();
        check("t5_brk_lat", (dec_q.size() > 0) ? dec_q[0] : -1, 7);
        repeat (12) tick();
        check("t5_no_acc", acc_q.size(), 0);
        brake_btn = 1'b0;
        repeat (10) tick();
        clear_log();
        repeat (20) tick();
        check("t5_lockout", acc_q.size() + dec_q.size(), 0);
        accel_btn = 1'b0;
        repeat (10) tick();
        clear_log();
        accel_btn = 1'b1;
        wait_acc("t5_resume");

        // T6: enable drop mid-repeat
        repeat (15) tick();
        check("t6_rpt_before", acc_q.size(), 3);
        enable = 1'b0;
        tick();
        check("t6_same_cycle", int'(accel_pulse), 0);
        repeat (9) tick();
        enable = 1'b1;
        clear_log();
        repeat (20) tick();
        check("t6_lock_after_en", acc_q.size(), 0);
        accel_btn = 1'b0;
        repeat (10) tick();
        clear_log();
        accel_btn = 1'b1;
        wait_acc("t6_repress");
        accel_btn = 1'b0;
        repeat (12) tick();

`ifdef PEDAL_COAST_DECEL_EN
        clear_log();
        repeat (45) tick();
        check("t6_coast_gap", (dec_q.size() >= 2) ? dec_q[1] - dec_q[0] : -1, 20);
`endif

        check("inv_exclusive", int'(both_seen), 0);
        check("inv_one_cycle", int'(wide_seen), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
